mc6502_interrupt_sequencer: RTL

//  Runs the 6502 reset, NMI, IRQ and BRK entry sequence at instruction boundaries.

---
 rtl/mc6502_pkg.sv | 35 +++
 rtl/mc6502_nmi_edge.sv | 35 +++
 rtl/mc6502_interrupt_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mc6502_pkg.sv
// Shared definitions for the 6502 interrupt entry sequencer: state encoding,
// entry source kinds, status-flag bit positions and the pushed-P formatter.
package mc6502_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RST_S  = 3'd1,
      ST_PUSH_H = 3'd2,
      ST_PUSH_L = 3'd3,
      ST_PUSH_P = 3'd4,
      ST_VEC_L  = 3'd5,
      ST_VEC_H  = 3'd6
   } is_state_t;

   typedef enum logic [1:0] {
      SRC_RST = 2'd0,
      SRC_NMI = 2'd1,
      SRC_BRK = 2'd2,
      SRC_IRQ = 2'd3
   } is_src_t;

   localparam int P_I = 2;
   localparam int P_B = 4;
   localparam int P_U = 5;

   // The stacked status byte always has U set; B marks a software BRK entry.
   function automatic logic [7:0] push_p(input logic [7:0] p, input logic brk);
      logic [7:0] r;
      r      = p;
      r[P_U] = 1'b1;
      r[P_B] = brk;
      return r;
   endfunction

endpackage

// File: rtl/mc6502_nmi_edge.sv
// NMI falling-edge detector with a pending latch; a fresh edge beats a
// simultaneous clear so no NMI is lost while one is being serviced.
module mc6502_nmi_edge (
   input  logic clk,
   input  logic rst_x,
   input  logic nmi_x,
   input  logic clr,
   output logic pend
);

   logic prev_r;
   logic pend_r;
   logic fall_s;

   assign fall_s = prev_r & ~nmi_x;
   assign pend   = pend_r;

   // line history and pending latch
   always_ff @(posedge clk or negedge rst_x) begin
      if (!rst_x) begin
         prev_r <= 1'b1;
         pend_r <= 1'b0;
      end else begin
         prev_r <= nmi_x;
         if (fall_s) begin
            pend_r <= 1'b1;
         end else if (clr) begin
            pend_r <= 1'b0;
         end else begin
            pend_r <= pend_r;
         end
      end
   end

endmodule

// File: rtl/mc6502_interrupt_sequencer.sv
// 6502 reset/NMI/IRQ/BRK entry sequencer: stacks PC and P, sets I and loads
// the vector into PC while holding instruction decode.
module mc6502_interrupt_sequencer
   import mc6502_pkg::*;
#(
   parameter logic [15:0] VEC_NMI    = 16'hFFFA,
   parameter logic [15:0] VEC_RST    = 16'hFFFC,
   parameter logic [15:0] VEC_IRQ    = 16'hFFFE,
   parameter logic [7:0]  STACK_PAGE = 8'h01
) (
   input  logic        clk,
   input  logic        rst_x,
   input  logic        i_nmi_x,
   input  logic        i_irq_x,
   input  logic        id2is_brk,
   input  logic        id2is_boundary,
   output logic        is2id_hold,
   input  logic [7:0]  rf2is_pcl,
   input  logic [7:0]  rf2is_pch,
   input  logic [7:0]  rf2is_s,
   input  logic [7:0]  rf2is_p,
   output logic [7:0]  is2rf_data,
   output logic        is2rf_set_pcl,
   output logic        is2rf_set_pch,
   output logic        is2rf_set_s,
   output logic        is2rf_set_i,
   output logic        is2mc_req,
   output logic        is2mc_we,
   output logic [15:0] is2mc_addr,
   output logic [7:0]  is2mc_data,
   input  logic        mc2is_ack,
   input  logic [7:0]  mc2is_data
);

   is_state_t   state_r;
   is_src_t     kind_r;
   is_src_t     src_s;
   logic [15:0] vec_r;
   logic [7:0]  pcl_r;
   logic [7:0]  s_r;
   logic [7:0]  s_dec_s;
   logic        hold_r;
   logic        take_s;
   logic        hijack_s;
   logic        nmi_pend_s;
   logic        nmi_clr_s;
   logic        req_r;
   logic        we_r;
   logic [15:0] addr_r;
   logic [7:0]  mdata_r;
   logic [7:0]  rdata_r;
   logic        set_pcl_r;
   logic        set_pch_r;
   logic        set_s_r;
   logic        set_i_r;

   mc6502_nmi_edge u_nmi (
      .clk   (clk),
      .rst_x (rst_x),
      .nmi_x (i_nmi_x),
      .clr   (nmi_clr_s),
      .pend  (nmi_pend_s)
   );

   assign s_dec_s    = s_r - 8'd1;
   assign nmi_clr_s  = (take_s && (src_s == SRC_NMI)) || hijack_s;
   assign is2id_hold = hold_r | take_s;

   assign is2rf_data    = rdata_r;
   assign is2rf_set_pcl = set_pcl_r;
   assign is2rf_set_pch = set_pch_r;
   assign is2rf_set_s   = set_s_r;
   assign is2rf_set_i   = set_i_r;
   assign is2mc_req     = req_r;
   assign is2mc_we      = we_r;
   assign is2mc_addr    = addr_r;
   assign is2mc_data    = mdata_r;

   // source selection at a boundary and NMI hijack of an IRQ/BRK entry
   always_comb begin
      take_s   = 1'b0;
      src_s    = SRC_IRQ;
      hijack_s = 1'b0;
      if ((state_r == ST_IDLE) && id2is_boundary) begin
         if (nmi_pend_s) begin
            take_s = 1'b1;
            src_s  = SRC_NMI;
         end else if (id2is_brk) begin
            take_s = 1'b1;
            src_s  = SRC_BRK;
         end else if (!i_irq_x && !rf2is_p[P_I]) begin
            take_s = 1'b1;
            src_s  = SRC_IRQ;
         end else begin
            take_s = 1'b0;
         end
      end else if ((state_r == ST_PUSH_P) && mc2is_ack && (kind_r != SRC_NMI)) begin
         hijack_s = nmi_pend_s;
      end else begin
         hijack_s = 1'b0;
      end
   end

   // sequence state, captured context and registered outputs
   always_ff @(posedge clk or negedge rst_x) begin
      if (!rst_x) begin
         state_r   <= ST_RST_S;
         hold_r    <= 1'b1;
         kind_r    <= SRC_RST;
         vec_r     <= VEC_RST;
         pcl_r     <= 8'h00;
         s_r       <= 8'h00;
         req_r     <= 1'b0;
         we_r      <= 1'b0;
         addr_r    <= 16'h0000;
         mdata_r   <= 8'h00;
         rdata_r   <= 8'h00;
         set_pcl_r <= 1'b0;
         set_pch_r <= 1'b0;
         set_s_r   <= 1'b0;
         set_i_r   <= 1'b0;
      end else begin
         set_pcl_r <= 1'b0;
         set_pch_r <= 1'b0;
         set_s_r   <= 1'b0;
         set_i_r   <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (take_s) begin
                  state_r <= ST_PUSH_H;
                  hold_r  <= 1'b1;
                  kind_r  <= src_s;
                  vec_r   <= (src_s == SRC_NMI) ? VEC_NMI : VEC_IRQ;
                  pcl_r   <= rf2is_pcl;
                  s_r     <= rf2is_s;
                  req_r   <= 1'b1;
                  we_r    <= 1'b1;
                  addr_r  <= {STACK_PAGE, rf2is_s};
                  mdata_r <= rf2is_pch;
               end else begin
                  hold_r <= 1'b0;
               end
            end
            ST_RST_S: begin
               // reset performs the three stack decrements without writing
               rdata_r <= rf2is_s - 8'd3;
               set_s_r <= 1'b1;
               set_i_r <= 1'b1;
               kind_r  <= SRC_RST;
               vec_r   <= VEC_RST;
               req_r   <= 1'b1;
               we_r    <= 1'b0;
               addr_r  <= VEC_RST;
               mdata_r <= 8'h00;
               state_r <= ST_VEC_L;
            end
            ST_PUSH_H: begin
               if (mc2is_ack) begin
                  s_r     <= s_dec_s;
                  addr_r  <= {STACK_PAGE, s_dec_s};
                  mdata_r <= pcl_r;
                  state_r <= ST_PUSH_L;
               end
            end
            ST_PUSH_L: begin
               if (mc2is_ack) begin
                  s_r     <= s_dec_s;
                  addr_r  <= {STACK_PAGE, s_dec_s};
                  mdata_r <= push_p(rf2is_p, kind_r == SRC_BRK);
                  state_r <= ST_PUSH_P;
               end
            end
            ST_PUSH_P: begin
               if (mc2is_ack) begin
                  s_r     <= s_dec_s;
                  rdata_r <= s_dec_s;
                  set_s_r <= 1'b1;
                  set_i_r <= 1'b1;
                  we_r    <= 1'b0;
                  mdata_r <= 8'h00;
                  if (hijack_s) begin
                     vec_r  <= VEC_NMI;
                     addr_r <= VEC_NMI;
                  end else begin
                     addr_r <= vec_r;
                  end
                  state_r <= ST_VEC_L;
               end
            end
            ST_VEC_L: begin
               if (mc2is_ack) begin
                  rdata_r   <= mc2is_data;
                  set_pcl_r <= 1'b1;
                  addr_r    <= vec_r + 16'd1;
                  state_r   <= ST_VEC_H;
               end
            end
            ST_VEC_H: begin
               if (mc2is_ack) begin
                  rdata_r   <= mc2is_data;
                  set_pch_r <= 1'b1;
                  req_r     <= 1'b0;
                  addr_r    <= 16'h0000;
                  hold_r    <= 1'b0;
                  state_r   <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_RST_S;
               hold_r  <= 1'b1;
               req_r   <= 1'b0;
               we_r    <= 1'b0;
            end
         endcase
      end
   end

endmodule
